// File: rtl/apb_pkg.sv
// apb_pkg: shared defaults, FSM state type and response codes for the APB wait responder.
package apb_pkg;

    localparam int ADDR_WIDTH = 9;
    localparam int DATA_WIDTH = 8;

    typedef enum logic {IDLE, ACCESS} state_e;

    localparam logic OKAY   = 1'b0;
    localparam logic SLVERR = 1'b1;

endpackage

// File: rtl/apb_resp_mem.sv
// apb_resp_mem: DEPTH x DATA_WIDTH register memory with async clear, one write port and a registered read port.
module apb_resp_mem #(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = apb_pkg::DATA_WIDTH,
    localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [IW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic                  rclr,
    input  logic [IW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // The read samples the array before this edge's write lands.
    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
        rdata_d = re ? (rclr ? '0 : mem_q[raddr]) : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/apb_wait_responder.sv
// apb_wait_responder: APB completer with a fixed number of wait states per access
// and PSLVERR for addresses beyond the memory depth.
module apb_wait_responder #(
    parameter int ADDR_WIDTH  = apb_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = apb_pkg::DATA_WIDTH,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    import apb_pkg::*;

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_e                state_q, state_d;
    logic [IW-1:0]         addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  setup, access, addr_err, mem_we;

    assign setup    = PSEL & ~PENABLE;
    assign access   = (state_q == ACCESS);
    assign addr_err = 32'(PADDR) >= 32'(DEPTH);
    assign PREADY   = access & (wait_q == '0) & PSEL & PENABLE;
    assign mem_we   = PREADY & write_q & ~err_q;
    assign PSLVERR  = (PREADY & err_q) ? SLVERR : OKAY;
    assign PRDATA   = (PREADY & ~write_q & ~err_q) ? rdata : '0;

    // A setup phase is honoured from either state, so a restart in ACCESS reloads everything.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        wait_d  = wait_q;
        if (setup) begin
            state_d = ACCESS;
            addr_d  = PADDR[IW-1:0];
            write_d = PWRITE;
            wdata_d = PWDATA;
            err_d   = addr_err;
            wait_d  = WW'(WAIT_CYCLES);
        end else if (access & (~PSEL | PREADY)) begin
            state_d = IDLE;
        end else if (access & (wait_q != '0)) begin
            wait_d = wait_q - 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    apb_resp_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .we    (mem_we),
        .waddr (addr_q),
        .wdata (wdata_q),
        .re    (setup),
        .rclr  (addr_err),
        .raddr (PADDR[IW-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_apb_wait_responder.sv
// tb_apb_wait_responder: drives a 2-wait and a zero-wait responder and checks
// them against a flat memory model built from the transfer rules.
module tb_apb_wait_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       psel [2];
    logic       pen [2];
    logic       pwr [2];
    logic [8:0] paddr [2];
    logic [7:0] pwdata [2];
    wire  [1:0]      pready;
    wire  [1:0]      pslverr;
    wire  [1:0][7:0] prdata;

    logic [7:0] mdl [2][256];
    int vectors = 0;
    int miscompares = 0;

    apb_wait_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .DEPTH(256), .WAIT_CYCLES(2)) u_w2 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(pen[0]), .PWRITE(pwr[0]),
        .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb_wait_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(pen[1]), .PWRITE(pwr[1]),
        .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int waits_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) mdl[d][i] = 8'h00;
    endtask

    // Called at posedge+1; returns at posedge+1 with the bus idle.
    // abort_after > 0 drops PSEL after that many wait cycles.
    task automatic xfer(input int d, input bit wr, input int addr, input logic [7:0] wd, input int abort_after);
        int n;
        bit err;
        logic [7:0] exp_rd;
        n = 0;
        err = (addr >= 256);
        exp_rd = (wr || err) ? 8'h00 : mdl[d][addr & 255];
        psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr; paddr[d] = 9'(addr); pwdata[d] = wd;
        @(posedge clk); #1 pen[d] = 1'b1;
        forever begin
            @(negedge clk);
            if (pready[d]) break;
            n++;
            if (n > 20) begin
                chk("ready_timeout", 32'(pready[d]), 32'd1);
                break;
            end
            if (n == abort_after) begin
                @(posedge clk); #1 psel[d] = 1'b0; pen[d] = 1'b0;
                @(negedge clk);
                chk("abort_no_ready", 32'(pready[d]), 32'd0);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        chk($sformatf("wait_cycles d%0d a%0h", d, addr), 32'(n), 32'(waits_of(d)));
        chk($sformatf("pslverr d%0d a%0h", d, addr), 32'(pslverr[d]), 32'(err));
        chk($sformatf("prdata d%0d a%0h", d, addr), 32'(prdata[d]), 32'(exp_rd));
        @(posedge clk); #1 psel[d] = 1'b0; pen[d] = 1'b0;
        if (wr && !err) mdl[d][addr] = wd;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; pen[d] = 1'b0; pwr[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
        end
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_pready", 32'(pready[d]), 32'd0);
            chk("reset_pslverr", 32'(pslverr[d]), 32'd0);
            chk("reset_prdata", 32'(prdata[d]), 32'd0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        xfer(0, 1'b1, 'h010, 8'hA5, -1);
        xfer(0, 1'b0, 'h010, 8'h00, -1);

        xfer(1, 1'b1, 'h0FF, 8'h3C, -1);
        xfer(1, 1'b0, 'h0FF, 8'h00, -1);

        xfer(0, 1'b1, 'h100, 8'h77, -1);
        xfer(0, 1'b0, 'h000, 8'h00, -1);
        xfer(0, 1'b0, 'h100, 8'h00, -1);

        xfer(0, 1'b1, 'h020, 8'hDE, 1);
        xfer(0, 1'b0, 'h020, 8'h00, -1);

        psel[0] = 1'b1; pen[0] = 1'b1; pwr[0] = 1'b1; paddr[0] = 9'h040; pwdata[0] = 8'h99;
        repeat (3) begin
            @(negedge clk);
            chk("violation_no_ready", 32'(pready[0]), 32'd0);
            @(posedge clk);
        end
        #1 psel[0] = 1'b0; pen[0] = 1'b0;
        xfer(0, 1'b0, 'h040, 8'h00, -1);
        xfer(0, 1'b1, 'h040, 8'h12, -1);
        xfer(0, 1'b0, 'h040, 8'h00, -1);

        // Reset lands while u_w2 is waiting on a write and u_w0 is presenting read data.
        xfer(1, 1'b1, 'h031, 8'h66, -1);
        psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b1; paddr[0] = 9'h030; pwdata[0] = 8'h55;
        psel[1] = 1'b1; pen[1] = 1'b0; pwr[1] = 1'b0; paddr[1] = 9'h031; pwdata[1] = 8'h00;
        @(posedge clk); #1 pen[0] = 1'b1; pen[1] = 1'b1;
        @(negedge clk);
        chk("pre_reset_w2_wait", 32'(pready[0]), 32'd0);
        chk("pre_reset_w0_ready", 32'(pready[1]), 32'd1);
        chk("pre_reset_w0_prdata", 32'(prdata[1]), 32'h66);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_w2_pready", 32'(pready[0]), 32'd0);
        chk("midreset_w2_pslverr", 32'(pslverr[0]), 32'd0);
        chk("midreset_w2_prdata", 32'(prdata[0]), 32'd0);
        chk("midreset_w0_pready", 32'(pready[1]), 32'd0);
        chk("midreset_w0_prdata", 32'(prdata[1]), 32'd0);
        @(posedge clk); #1 psel[0] = 1'b0; pen[0] = 1'b0; psel[1] = 1'b0; pen[1] = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        clear_model();
        @(posedge clk); #1;
        xfer(0, 1'b0, 'h030, 8'h00, -1);
        xfer(1, 1'b0, 'h031, 8'h00, -1);

        repeat (120) begin
            int d, addr, ab;
            bit wr;
            d = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(256, 511)) : int'($urandom_range(0, 31));
            ab = (d == 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : -1;
            xfer(d, wr, addr, 8'($urandom), ab);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
